ysyx_24100005_state_elements: RTL and testbench

State-holding block of the ysyx_24100005 single-cycle RV32 core: one general-purpose resettable register with write enable (used as the program counter) and a multi-entry register file (the integer register file x0–x31). Both sit on the same clock and asynchronous reset. The core's datapath feeds next-PC and write-back data in and consumes the PC and operand values combinationally.

---
 rtl/ysyx_24100005_state_elements.sv | 51 +++++
 tb/tb_ysyx_24100005_state_elements.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24100005_state_elements.sv
// State elements of the ysyx_24100005 RV32 core: the program counter register
// and the 32-entry integer register file with x0 hardwired to zero.
module ysyx_24100005_state_elements #(
  parameter int unsigned          REG_WIDTH     = 32,
  parameter logic [REG_WIDTH-1:0] REG_RESET_VAL = 32'h8000_0000,
  parameter int unsigned          ADDR_WIDTH    = 5,
  parameter int unsigned          DATA_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_WIDTH-1:0]  reg_din,
  input  logic                  reg_wen,
  output logic [REG_WIDTH-1:0]  reg_dout,
  input  logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] rf_waddr,
  input  logic                  rf_wen,
  input  logic [ADDR_WIDTH-1:0] rf_raddr1,
  output logic [DATA_WIDTH-1:0] rf_rdata1,
  input  logic [ADDR_WIDTH-1:0] rf_raddr2,
  output logic [DATA_WIDTH-1:0] rf_rdata2
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [REG_WIDTH-1:0]  pc_q;
  logic [DATA_WIDTH-1:0] regs [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= REG_RESET_VAL;
    end else if (reg_wen) begin
      pc_q <= reg_din;
    end
  end

  // Entry 0 is cleared by reset and never written, so it stays zero forever.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (rf_wen && (rf_waddr != '0)) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  assign reg_dout  = pc_q;
  assign rf_rdata1 = (rf_raddr1 == '0) ? '0 : regs[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == '0) ? '0 : regs[rf_raddr2];

endmodule

// File: tb/tb_ysyx_24100005_state_elements.sv
// Directed, table-driven bench for ysyx_24100005_state_elements: PC stepping,
// register-file writes/reads, x0 behaviour and asynchronous reset.
module tb_ysyx_24100005_state_elements;

  logic        clk;
  logic        rst;
  logic [31:0] reg_din;
  logic        reg_wen;
  logic [31:0] reg_dout;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_waddr;
  logic        rf_wen;
  logic [4:0]  rf_raddr1;
  logic [31:0] rf_rdata1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata2;

  int total;
  int bad;

  typedef struct {
    logic        reg_wen;
    logic [31:0] reg_din;
    logic        rf_wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] exp_reg;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
  } vec_t;

  vec_t vecs [8];

  ysyx_24100005_state_elements dut (
    .clk       (clk),
    .rst       (rst),
    .reg_din   (reg_din),
    .reg_wen   (reg_wen),
    .reg_dout  (reg_dout),
    .rf_wdata  (rf_wdata),
    .rf_waddr  (rf_waddr),
    .rf_wen    (rf_wen),
    .rf_raddr1 (rf_raddr1),
    .rf_rdata1 (rf_rdata1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata2 (rf_rdata2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rw, input logic [31:0] rd,
                               input logic fw, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [4:0] a1,
                               input logic [4:0] a2);
    reg_wen   = rw;
    reg_din   = rd;
    rf_wen    = fw;
    rf_waddr  = wa;
    rf_wdata  = wd;
    rf_raddr1 = a1;
    rf_raddr2 = a2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] got,
                             input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Reads every address on both ports with writes disabled.
  task automatic sweepZero(input string name);
    for (int a = 0; a < 32; a++) begin
      rf_raddr1 = 5'(a);
      rf_raddr2 = 5'(31 - a);
      #1;
      checkOutput({name, "_rd1"}, rf_rdata1, 32'h0);
      checkOutput({name, "_rd2"}, rf_rdata2, 32'h0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

    vecs[0] = '{1'b1, 32'h8000_0004, 1'b0, 5'd0,  32'h0,         5'd0,  5'd0,  32'h8000_0004, 32'h0,         32'h0};
    vecs[1] = '{1'b1, 32'h8000_0008, 1'b1, 5'd5,  32'hDEAD_BEEF, 5'd5,  5'd31, 32'h8000_0008, 32'hDEAD_BEEF, 32'h0};
    vecs[2] = '{1'b1, 32'h8000_000C, 1'b1, 5'd31, 32'h1234_5678, 5'd5,  5'd31, 32'h8000_000C, 32'hDEAD_BEEF, 32'h1234_5678};
    vecs[3] = '{1'b1, 32'h8000_0010, 1'b1, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd0,  32'h8000_0010, 32'h0,         32'h0};
    vecs[4] = '{1'b0, 32'h0,         1'b1, 5'd7,  32'h0BAD_F00D, 5'd7,  5'd5,  32'h8000_0010, 32'h0BAD_F00D, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 32'h0,         1'b0, 5'd7,  32'hA5A5_A5A5, 5'd7,  5'd7,  32'h8000_0010, 32'h0BAD_F00D, 32'h0BAD_F00D};
    vecs[6] = '{1'b0, 32'h1,         1'b1, 5'd31, 32'h0000_0031, 5'd31, 5'd5,  32'h8000_0010, 32'h0000_0031, 32'hDEAD_BEEF};
    vecs[7] = '{1'b1, 32'h0000_0100, 1'b1, 5'd1,  32'h0000_0001, 5'd1,  5'd7,  32'h0000_0100, 32'h0000_0001, 32'h0BAD_F00D};

    repeat (2) @(negedge clk);
    checkOutput("reset_pc", reg_dout, 32'h8000_0000);
    sweepZero("reset_rf");

    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].reg_wen, vecs[i].reg_din, vecs[i].rf_wen,
                    vecs[i].waddr, vecs[i].wdata, vecs[i].raddr1, vecs[i].raddr2);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_pc", i), reg_dout, vecs[i].exp_reg);
      checkOutput($sformatf("vec%0d_rd1", i), rf_rdata1, vecs[i].exp_rd1);
      checkOutput($sformatf("vec%0d_rd2", i), rf_rdata2, vecs[i].exp_rd2);
    end

    // No bypass: old value before the edge, new value after it.
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1, 5'd5, 32'hCAFE_0001, 5'd5, 5'd5);
    #1;
    checkOutput("nobypass_before", rf_rdata1, 32'hDEAD_BEEF);
    @(posedge clk);
    #1;
    checkOutput("nobypass_after", rf_rdata2, 32'hCAFE_0001);

    // Combinational read follows an address change mid-cycle.
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    #1;
    checkOutput("comb_read_a", rf_rdata1, 32'h0BAD_F00D);
    rf_raddr1 = 5'd31;
    #1;
    checkOutput("comb_read_b", rf_rdata1, 32'h0000_0031);

    // Fill x1..x31 and advance the PC before the mid-cycle reset pulse.
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      applyStimulus(1'b1, 32'h8000_0000 + 32'(i * 4), 1'b1, 5'(i),
                    32'h5A00_0000 | 32'(i), 5'd1, 5'd31);
    end
    @(posedge clk);
    #1;
    checkOutput("fill_pc", reg_dout, 32'h8000_007C);
    checkOutput("fill_x1", rf_rdata1, 32'h5A00_0001);
    checkOutput("fill_x31", rf_rdata2, 32'h5A00_001F);

    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd31);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("pulse_pc", reg_dout, 32'h8000_0000);
    checkOutput("pulse_x1", rf_rdata1, 32'h0);
    checkOutput("pulse_x31", rf_rdata2, 32'h0);
    #1;
    rst = 1'b0;
    sweepZero("pulse_rf");
    checkOutput("pulse_pc_hold", reg_dout, 32'h8000_0000);

    @(negedge clk);
    applyStimulus(1'b1, 32'h8000_0004, 1'b1, 5'd3, 32'h0000_0033, 5'd3, 5'd1);
    @(posedge clk);
    #1;
    checkOutput("post_reset_pc", reg_dout, 32'h8000_0004);
    checkOutput("post_reset_x3", rf_rdata1, 32'h0000_0033);
    checkOutput("post_reset_x1", rf_rdata2, 32'h0);

    // Reset held across an edge with both writes enabled: reset wins.
    @(negedge clk);
    applyStimulus(1'b1, 32'h1234_0000, 1'b1, 5'd9, 32'h9999_9999, 5'd9, 5'd3);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_wins_pc", reg_dout, 32'h8000_0000);
    checkOutput("rst_wins_x9", rf_rdata1, 32'h0);
    checkOutput("rst_wins_x3", rf_rdata2, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("release_pc", reg_dout, 32'h1234_0000);
    checkOutput("release_x9", rf_rdata1, 32'h9999_9999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
